// File: rtl/keypad_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | keypad_pkg : shared types and helpers for the 4x4 keypad scan controller  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package keypad_pkg;

  localparam int NUM_ROWS  = 4;
  localparam int NUM_COLS  = 4;
  localparam int KEY_W     = 4;
  localparam int ROW_IDX_W = 2;
  localparam int COL_IDX_W = 2;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

  // Row 0 has the highest priority when several rows conduct at once.
  function automatic logic [ROW_IDX_W-1:0] lowest_row(input logic [NUM_ROWS-1:0] rows);
    logic [ROW_IDX_W-1:0] idx;
    idx = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (rows[r]) idx = ROW_IDX_W'(r);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_stable_cnt.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | keypad_stable_cnt : counts consecutive cycles din == level, flags terminal |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module keypad_stable_cnt
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 1000,
  parameter int CNT_W        = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic start,
  input  logic din,
  input  logic level,
  output logic hit
);

  localparam logic [CNT_W-1:0] c_terminal = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] c_last     = CNT_W'(DEBOUNCE_CNT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             match;

  // hit fires on the sample that brings the run length up to DEBOUNCE_CNT.
  always_comb begin
    match = (din == level);
    hit   = match && (cnt_q == c_last);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = CNT_W'(1);
    end else if (!match) begin
      cnt_d = '0;
    end else if (cnt_q != c_terminal) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | keypad_scan_ctrl : 4x4 keypad column scan, press/release debounce, keycode |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(SCAN_DIV - 1);

  scan_state_t            state_q, state_d;
  logic [COL_IDX_W-1:0]   col_idx_q, col_idx_d;
  logic [ROW_IDX_W-1:0]   row_idx_q, row_idx_d;
  logic [CNT_W-1:0]       dwell_q, dwell_d;
  logic [NUM_COLS-1:0]    col_q, col_d;
  logic [KEY_W-1:0]       key_code_q, key_code_d;
  logic                   key_valid_q, key_valid_d;
  logic                   key_held_q, key_held_d;

  logic                   cnt_clr;
  logic                   cnt_start;
  logic                   cnt_level;
  logic                   cnt_hit;
  logic [ROW_IDX_W-1:0]   det_row;

  keypad_stable_cnt #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .CNT_W        (CNT_W)
  ) u_stable_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .start (cnt_start),
    .din   (row[row_idx_q]),
    .level (cnt_level),
    .hit   (cnt_hit)
  );

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    dwell_d     = dwell_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    cnt_clr     = 1'b0;
    cnt_start   = 1'b0;
    cnt_level   = 1'b1;
    det_row     = lowest_row(row);

    unique case (state_q)
      SCAN: begin
        if (dwell_q == c_dwell_last) begin
          dwell_d = '0;
          if (row == '0) begin
            col_idx_d = col_idx_q + COL_IDX_W'(1);
          end else begin
            row_idx_d = det_row;
            // The detecting sample is the first of the DEBOUNCE_CNT stable samples.
            if (DEBOUNCE_CNT == 1) begin
              key_code_d  = {det_row, col_idx_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_clr     = 1'b1;
              state_d     = HELD;
            end else begin
              cnt_start = 1'b1;
              state_d   = DEBOUNCE;
            end
          end
        end else begin
          dwell_d = dwell_q + CNT_W'(1);
        end
      end

      DEBOUNCE: begin
        cnt_level = 1'b1;
        if (!row[row_idx_q]) begin
          col_idx_d = col_idx_q + COL_IDX_W'(1);
          cnt_clr   = 1'b1;
          state_d   = SCAN;
        end else if (cnt_hit) begin
          key_code_d  = {row_idx_q, col_idx_q};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          cnt_clr     = 1'b1;
          state_d     = HELD;
        end
      end

      HELD: begin
        cnt_level = 1'b0;
        if (cnt_hit) begin
          key_held_d = 1'b0;
          col_idx_d  = col_idx_q + COL_IDX_W'(1);
          cnt_clr    = 1'b1;
          state_d    = SCAN;
        end
      end

      default: begin
        cnt_clr   = 1'b1;
        col_idx_d = '0;
        dwell_d   = '0;
        state_d   = SCAN;
      end
    endcase

    col_d = NUM_COLS'(1) << col_idx_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      col_idx_q   <= '0;
      row_idx_q   <= '0;
      dwell_q     <= '0;
      col_q       <= NUM_COLS'(1);
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      dwell_q     <= dwell_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_keypad_scan_ctrl : directed bench with a closed-loop 4x4 keypad model  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_keypad_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] key;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int dbl_cnt  = 0;
  int viol_cnt = 0;
  logic prev_valid = 1'b0;
  logic prev_held  = 1'b0;

  keypad_scan_ctrl #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // key index = 4*row + col; a row conducts when a pressed key sits on the driven column
  always_comb begin
    row = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key[r*4+c] && col[c]) row[r] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) pulses++;
      if (key_valid && prev_valid) dbl_cnt++;
      if (key_valid && prev_held) viol_cnt++;
    end
    prev_valid = key_valid;
    prev_held  = key_held;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_col(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    while (col !== target && n < 64) begin
      tick(1);
      n++;
    end
    check(tag, col, target);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < 64) begin
      tick(1);
      n++;
    end
    check(tag, key_valid, 1);
  endtask

  initial begin
    int p0;
    int quiet;
    rst = 1'b1;
    key = '0;
    tick(1);
    rst = 1'b0;

    // reset state and idle scan order
    check("rst_col", col, 4'b0001);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_code", key_code, 0);
    tick(4);  check("scan_c1", col, 4'b0010);
    tick(4);  check("scan_c2", col, 4'b0100);
    tick(4);  check("scan_c3", col, 4'b1000);
    tick(4);  check("scan_wrap", col, 4'b0001);
    quiet = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (key_valid !== 1'b0 || key_held !== 1'b0) quiet++;
    end
    check("idle_quiet", quiet, 0);

    // key 6: latency from the column-2 sample, then debounced release
    wait_col(4'b0010, "k6_pre_col");
    key[6] = 1'b1;
    wait_col(4'b0100, "k6_col");
    p0 = pulses;
    tick(10); check("k6_early", key_valid, 0);
    tick(1);  check("k6_valid", key_valid, 1);
    check("k6_code", key_code, 6);
    check("k6_held", key_held, 1);
    tick(1);  check("k6_pulse_end", key_valid, 0);
    tick(20); check("k6_hold", key_held, 1);
    check("k6_col_hold", col, 4'b0100);
    check("k6_one_pulse", pulses, p0 + 1);
    key[6] = 1'b0;
    tick(7);  check("k6_rel_early", key_held, 1);
    tick(1);  check("k6_rel", key_held, 0);
    check("k6_next_col", col, 4'b1000);

    // key 9 bounce: sample + 3 debounce cycles high, then low
    wait_col(4'b0010, "k9_col");
    p0 = pulses;
    tick(3);  key[9] = 1'b1;
    tick(4);  key[9] = 1'b0;
    tick(1);  check("k9_resume_col", col, 4'b0100);
    tick(20); check("k9_no_pulse", pulses, p0);
    check("k9_no_held", key_held, 0);

    // keys 1 and 9 together, key 15 during hold
    key[1] = 1'b1;
    key[9] = 1'b1;
    p0 = pulses;
    wait_valid("k1_valid");
    check("k1_code", key_code, 1);
    tick(5);  key[15] = 1'b1;
    tick(20); check("k1_hold", key_held, 1);
    check("k1_col_hold", col, 4'b0010);
    check("k15_ignored", pulses, p0 + 1);
    key[1] = 1'b0;
    key[9] = 1'b0;
    tick(7);  check("k1_rel_early", key_held, 1);
    tick(1);  check("k1_rel", key_held, 0);
    check("k1_next_col", col, 4'b0100);
    wait_valid("k15_valid");
    check("k15_code", key_code, 15);
    check("k15_col", col, 4'b1000);
    tick(3);  key[15] = 1'b0;
    tick(8);  check("k15_rel", key_held, 0);
    check("k15_wrap_col", col, 4'b0001);

    // reset while holding key 12
    key[12] = 1'b1;
    wait_valid("k12_valid");
    check("k12_code", key_code, 12);
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("k12_rst_col", col, 4'b0001);
    check("k12_rst_held", key_held, 0);
    check("k12_rst_valid", key_valid, 0);
    check("k12_rst_code", key_code, 0);
    tick(10); check("k12_re_early", key_valid, 0);
    tick(1);  check("k12_re_valid", key_valid, 1);
    check("k12_re_code", key_code, 12);
    tick(3);  key[12] = 1'b0;
    tick(8);  check("k12_rel", key_held, 0);
    check("k12_next_col", col, 4'b0010);

    // key 3 release chatter
    key[3] = 1'b1;
    p0 = pulses;
    wait_valid("k3_valid");
    check("k3_code", key_code, 3);
    tick(5);  key[3] = 1'b0;
    tick(5);  check("k3_chatter_held", key_held, 1);
    key[3] = 1'b1;
    tick(5);  key[3] = 1'b0;
    tick(7);  check("k3_rel_early", key_held, 1);
    tick(1);  check("k3_rel", key_held, 0);
    check("k3_one_pulse", pulses, p0 + 1);
    check("k3_wrap_col", col, 4'b0001);

    check("no_double_pulse", dbl_cnt, 0);
    check("no_pulse_while_held", viol_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
